// File: rtl/nv_pingpong_pkg.sv
// rtl/nv_pingpong_pkg.sv - shared types and occupancy constants for the ping-pong buffer
package nv_pingpong_pkg;

  typedef logic [1:0] pp_cnt_t;

  localparam int      PP_DEPTH = 2;
  localparam pp_cnt_t PP_FULL  = pp_cnt_t'(PP_DEPTH);
  localparam pp_cnt_t PP_EMPTY = 2'd0;

endpackage

// File: rtl/nv_pingpong_bank.sv
// rtl/nv_pingpong_bank.sv - one DW-wide storage bank with write enable and sync reset value
module nv_pingpong_bank #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nv_pingpong_buf.sv
// rtl/nv_pingpong_buf.sv - two-entry ping-pong buffer; NV_PINGPONG_BYPASS_EN adds an empty-buffer pass-through
module nv_pingpong_buf
  import nv_pingpong_pkg::*;
#(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sel,
  output logic [1:0]    count
);

  logic          wr_ptr;
  logic          rd_ptr;
  pp_cnt_t       cnt;
  logic [DW-1:0] bank0_q;
  logic [DW-1:0] bank1_q;
  logic          push;
  logic          pop;
  logic          bypass;

`ifdef NV_PINGPONG_BYPASS_EN
  // Pass-through only when nothing is stored, so ordering is preserved.
  assign bypass = ~nvdla_core_rst & (cnt == PP_EMPTY) & in_valid & out_ready;
`else
  assign bypass = 1'b0;
`endif

  // in_ready depends on registered count only, keeping out_ready off this path.
  assign in_ready  = ~nvdla_core_rst & (cnt != PP_FULL);
  assign out_valid = ~nvdla_core_rst & ((cnt != PP_EMPTY) | bypass);
  assign out_data  = bypass ? in_data : (rd_ptr ? bank1_q : bank0_q);
  assign out_sel   = rd_ptr;
  assign count     = cnt;

  assign push = in_valid & in_ready & ~bypass;
  assign pop  = out_valid & out_ready & ~bypass;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= PP_EMPTY;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  nv_pingpong_bank #(.DW(DW), .RST_VAL(RST_VAL)) u_bank0 (
    .clk (nvdla_core_clk),
    .rst (nvdla_core_rst),
    .we  (push & ~wr_ptr),
    .d   (in_data),
    .q   (bank0_q)
  );

  nv_pingpong_bank #(.DW(DW), .RST_VAL(RST_VAL)) u_bank1 (
    .clk (nvdla_core_clk),
    .rst (nvdla_core_rst),
    .we  (push & wr_ptr),
    .d   (in_data),
    .q   (bank1_q)
  );

endmodule

// File: tb/tb_nv_pingpong_buf.sv
// tb/tb_nv_pingpong_buf.sv - self-checking bench for nv_pingpong_buf against a queue-based reference
module tb_nv_pingpong_buf;

  localparam int          DW    = 32;
  localparam logic [31:0] RSTV  = 32'hDEAD_BEEF;
`ifdef NV_PINGPONG_BYPASS_EN
  localparam bit          BYP_EN = 1'b1;
`else
  localparam bit          BYP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sel;
  logic [1:0]    count;

  int vectors = 0;
  int miscompares = 0;

  // Reference: beats in flight, pops since reset, and whether banks still hold reset value.
  logic [31:0] q[$];
  int          pops = 0;
  bit          fresh = 1'b1;
  bit          acc;
  logic        cur_v;
  logic [31:0] cur_d;

  always #5 clk = ~clk;

  nv_pingpong_buf #(.DW(DW), .RST_VAL(RSTV)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sel        (out_sel),
    .count          (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic step(input logic r_in, input logic v, input logic [31:0] d, input logic r,
                      output bit accepted);
    bit byp, ex_ir, ex_ov, push, pop;
    rst = r_in; in_valid = v; in_data = d; out_ready = r;
    #1;
    byp   = BYP_EN && !r_in && q.size() == 0 && v && r;
    ex_ir = !r_in && q.size() < 2;
    ex_ov = !r_in && (q.size() > 0 || byp);
    chk("in_ready", {31'd0, in_ready}, {31'd0, ex_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ex_ov});
    if (!r_in) begin
      chk("count", {30'd0, count}, q.size());
      chk("out_sel", {31'd0, out_sel}, pops % 2);
      if (byp)              chk("out_data_bypass", out_data, d);
      else if (q.size() > 0) chk("out_data", out_data, q[0]);
      else if (fresh)       chk("out_data_rstval", out_data, RSTV);
    end
    push = v && ex_ir && !byp;
    pop  = ex_ov && r && !byp;
    accepted = push || byp;
    @(posedge clk);
    if (r_in) begin
      q.delete(); pops = 0; fresh = 1'b1;
    end else begin
      if (pop)  begin void'(q.pop_front()); pops++; end
      if (push) begin q.push_back(d); fresh = 1'b0; end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, acc);
    step(1, 0, 0, 0, acc);
    repeat (3) step(0, 0, 0, 0, acc);

    step(0, 1, 32'hA5A5_0001, 0, acc);
    step(0, 0, 0, 0, acc);
    step(0, 0, 0, 1, acc);

    step(0, 1, 32'h11, 0, acc);
    step(0, 1, 32'h22, 0, acc);
    step(0, 1, 32'h33, 0, acc);
    step(0, 1, 32'h33, 0, acc);
    step(0, 1, 32'h33, 1, acc);
    step(0, 1, 32'h33, 1, acc);
    step(0, 0, 0, 1, acc);
    step(0, 0, 0, 1, acc);

    for (int i = 0; i < 16; i++) step(0, 1, i, 1, acc);
    step(0, 0, 0, 1, acc);

    step(0, 1, 32'hB1, 0, acc);
    step(0, 1, 32'hB2, 0, acc);
    step(1, 0, 0, 0, acc);
    step(0, 0, 0, 1, acc);
    step(0, 1, 32'hC3, 0, acc);
    step(0, 0, 0, 1, acc);
    step(0, 0, 0, 0, acc);

    step(0, 1, 32'h77, 1, acc);
    step(0, 0, 0, 0, acc);

    cur_v = 1'b0; cur_d = '0;
    for (int i = 0; i < 400; i++) begin
      logic do_rst;
      do_rst = ($urandom_range(99) < 2);
      step(do_rst, cur_v, cur_d, logic'($urandom_range(1)), acc);
      if (acc || !cur_v || do_rst) begin
        cur_v = logic'($urandom_range(1));
        cur_d = $urandom;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
